// File: rtl/pio_pkg.sv
// Shared constants for the parametrised input PIO: register addresses,
// edge-type selection and irq-mode selection encodings.
package pio_pkg;

    // Register map of the slave (2-bit word address).
    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_MASK = 2'd1,
        ADDR_RSVD = 2'd2,
        ADDR_EDGE = 2'd3
    } pio_addr_e;

    // EDGE_TYPE parameter encodings.
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // IRQ_MODE parameter encodings.
    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, post-reset prime counter and per-bit edge detector.
// edge_det is combinational and is held at zero until the synchroniser
// chain and the previous-sample register have been refilled after reset.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] d_sync,
    output logic [DATA_WIDTH-1:0] edge_det
);

    localparam int                CNT_W     = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]  PRIME_MAX = CNT_W'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] sync_pipe [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] d_prev;
    logic [CNT_W-1:0]      prime_cnt;
    logic                  primed;
    logic [DATA_WIDTH-1:0] rise;
    logic [DATA_WIDTH-1:0] fall;
    logic [DATA_WIDTH-1:0] edge_sel;

    // Synchroniser chain: in_port reaches d_sync after SYNC_STAGES clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_pipe[i] <= '0;
            end
        end else begin
            sync_pipe[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign d_sync = sync_pipe[SYNC_STAGES-1];

    // Previous synchronised sample, compared against d_sync for edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_prev <= '0;
        end else begin
            d_prev <= d_sync;
        end
    end

    // Prime counter: saturates once chain and d_prev hold real input data,
    // so an input already high at reset release is not seen as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
        end else if (prime_cnt != PRIME_MAX) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    assign primed = (prime_cnt == PRIME_MAX);
    assign rise   = d_sync & ~d_prev;
    assign fall   = ~d_sync & d_prev;

    // Edge polarity selection, fixed at elaboration.
    always_comb begin
        edge_sel = rise | fall;
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_sel = rise;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            edge_sel = fall;
        end
    end

    assign edge_det = primed ? edge_sel : '0;

endmodule

// File: rtl/pio_input_edge_irq.sv
// Avalon-MM input PIO with sticky per-bit edge capture and maskable irq.
// Register file, read mux and irq generation live here; synchronisation
// and edge detection are in pio_sync_edge.
module pio_input_edge_irq
    import pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    EDGE_TYPE   = EDGE_RISE,
    parameter int                    IRQ_MODE    = IRQ_EDGE,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] d_sync;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] edge_cap;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] edge_clr;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  wr_en;
    logic                  irq_src;

    pio_sync_edge #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .d_sync   (d_sync),
        .edge_det (edge_det)
    );

    // Bits above DATA_WIDTH on the write bus are simply not used.
    assign wr_en    = chipselect & ~write_n;
    assign wdata    = writedata[DATA_WIDTH-1:0];
    assign edge_clr = (wr_en && (address == ADDR_EDGE)) ? wdata : '0;

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= RESET_VALUE;
        end else if (wr_en && (address == ADDR_MASK)) begin
            irq_mask <= wdata;
        end
    end

    // Sticky edge capture: a new edge wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= edge_det | (edge_cap & ~edge_clr);
        end
    end

    // Read mux over the current register contents.
    always_comb begin
        rd_mux = '0;
        case (pio_addr_e'(address))
            ADDR_DATA: rd_mux = d_sync;
            ADDR_MASK: rd_mux = irq_mask;
            ADDR_RSVD: rd_mux = '0;
            ADDR_EDGE: rd_mux = edge_cap;
            default:   rd_mux = '0;
        endcase
    end

    // Registered read data, refreshed every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= 32'(rd_mux);
        end
    end

    assign irq_src = (IRQ_MODE == IRQ_EDGE) ? |(edge_cap & irq_mask)
                                            : |(d_sync & irq_mask);

    // Registered interrupt request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_src;
        end
    end

endmodule

// File: tb/tb_pio_input_edge_irq.sv
// Bench for pio_input_edge_irq: two instances (32-bit rising-edge/edge-irq
// and 8-bit any-edge/level-irq) on a shared bus, checked every cycle
// against a delay-line reference model, plus a directed vector table.
module tb_pio_input_edge_irq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = 2'd3;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] in_a = 32'hFFFF_FFFF;
    logic [7:0]  in_b = 8'hFF;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pio_input_edge_irq dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    pio_input_edge_irq #(
        .DATA_WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_MODE(0), .RESET_VALUE(8'hA5)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    // Per-instance configuration: [0] = dut_a, [1] = dut_b.
    int          cfg_s[2]    = '{2, 3};
    int          cfg_edge[2] = '{0, 2};
    int          cfg_irqm[2] = '{1, 0};
    logic [31:0] cfg_wm[2]   = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] cfg_rst[2]  = '{32'h0, 32'hA5};

    // Reference model: input history indexed by clock edge since reset.
    logic [31:0] hist [2][4096];
    int          m_n[2];
    logic [31:0] m_mask[2], m_ec[2], m_rd[2];
    logic        m_irq[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i]    = 0;
            m_mask[i] = cfg_rst[i];
            m_ec[i]   = '0;
            m_rd[i]   = '0;
            m_irq[i]  = 1'b0;
        end
    endtask

    // Predict register state after the coming clock edge from present inputs.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] cur, ds, dp, ed, clr, wm;
            int n, s;
            logic wr;
            wm  = cfg_wm[i];
            n   = m_n[i];
            s   = cfg_s[i];
            cur = (i == 0) ? in_a : {24'h0, in_b};
            // synchronised value is the input seen s edges ago
            ds  = (n - s + 1 >= 1) ? hist[i][n-s+1] : 32'h0;
            dp  = (n - s >= 1) ? hist[i][n-s] : 32'h0;
            case (cfg_edge[i])
                0:       ed = ds & ~dp;
                1:       ed = ~ds & dp;
                default: ed = ds ^ dp;
            endcase
            if (n < s + 1) ed = '0;
            wr = chipselect && !write_n;
            case (address)
                2'd0:    m_rd[i] = ds;
                2'd1:    m_rd[i] = m_mask[i];
                2'd3:    m_rd[i] = m_ec[i];
                default: m_rd[i] = '0;
            endcase
            m_irq[i] = (cfg_irqm[i] == 1) ? |(m_ec[i] & m_mask[i]) : |(ds & m_mask[i]);
            clr = (wr && address == 2'd3) ? (writedata & wm) : 32'h0;
            m_ec[i] = ed | (m_ec[i] & ~clr);
            if (wr && address == 2'd1) m_mask[i] = writedata & wm;
            if (n < 4095) begin
                m_n[i] = n + 1;
                hist[i][n+1] = cur & wm;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("rd_a", rd_a, m_rd[0]);
        check("irq_a", {31'h0, irq_a}, {31'h0, m_irq[0]});
        check("rd_b", rd_b, m_rd[1]);
        check("irq_b", {31'h0, irq_b}, {31'h0, m_irq[1]});
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without a clock.
    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_rd_a", rd_a, 32'h0);
        check("async_rst_irq_a", {31'h0, irq_a}, 32'h0);
        check("async_rst_rd_b", rd_b, 32'h0);
        check("async_rst_irq_b", {31'h0, irq_b}, 32'h0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic bus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
    endtask

    typedef struct {
        logic [31:0] in_v;
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        int          ncyc;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Directed sequence for dut_a starting at reset release, input high.
        tbl[0]  = '{32'hFFFF_FFFF, 2'd3, 1'b0, 1'b1, 32'h0,  10, 32'h0,         1'b0};
        tbl[1]  = '{32'hFFFF_FFFF, 2'd0, 1'b0, 1'b1, 32'h0,   1, 32'hFFFF_FFFF, 1'b0};
        tbl[2]  = '{32'h0,         2'd1, 1'b1, 1'b0, 32'h1,   1, 32'h0,         1'b0};
        tbl[3]  = '{32'h0,         2'd1, 1'b0, 1'b1, 32'h0,   4, 32'h1,         1'b0};
        tbl[4]  = '{32'h1,         2'd3, 1'b0, 1'b1, 32'h0,   2, 32'h0,         1'b0};
        tbl[5]  = '{32'h1,         2'd3, 1'b0, 1'b1, 32'h0,   1, 32'h0,         1'b0};
        tbl[6]  = '{32'h1,         2'd3, 1'b0, 1'b1, 32'h0,   1, 32'h1,         1'b1};
        tbl[7]  = '{32'h1,         2'd3, 1'b1, 1'b0, 32'h1,   1, 32'h1,         1'b1};
        tbl[8]  = '{32'h1,         2'd3, 1'b0, 1'b1, 32'h0,   1, 32'h0,         1'b0};
        tbl[9]  = '{32'h21,        2'd3, 1'b0, 1'b1, 32'h0,   2, 32'h0,         1'b0};
        tbl[10] = '{32'h21,        2'd3, 1'b1, 1'b0, 32'h20,  1, 32'h0,         1'b0};
        tbl[11] = '{32'h21,        2'd3, 1'b0, 1'b1, 32'h0,   1, 32'h20,        1'b0};
        tbl[12] = '{32'h21,        2'd3, 1'b1, 1'b0, 32'h20,  1, 32'h20,        1'b0};
        tbl[13] = '{32'h21,        2'd3, 1'b0, 1'b1, 32'h0,   1, 32'h0,         1'b0};

        model_reset();
        apply_reset();

        for (int r = 0; r < 14; r++) begin
            in_a = tbl[r].in_v;
            bus(tbl[r].addr, tbl[r].cs, tbl[r].wn, tbl[r].wd);
            for (int c = 0; c < tbl[r].ncyc; c++) step();
            check($sformatf("vec%0d_rd", r), rd_a, tbl[r].exp_rd);
            check($sformatf("vec%0d_irq", r), {31'h0, irq_a}, {31'h0, tbl[r].exp_irq});
        end

        // Randomised traffic on both instances against the model.
        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(0, 3) == 0) in_a = in_a ^ $urandom;
            if ($urandom_range(0, 3) == 0) in_b = in_b ^ 8'($urandom);
            bus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), $urandom);
            step();
        end

        // Build edgecapture = 0xF with mask = 0xF, then reset mid-operation.
        bus(2'd3, 1'b0, 1'b1, 32'h0);
        in_a = 32'h0;
        in_b = 8'h0;
        repeat (5) step();
        bus(2'd1, 1'b1, 1'b0, 32'hF);
        step();
        bus(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
        step();
        bus(2'd3, 1'b0, 1'b1, 32'h0);
        step();
        in_a = 32'hF;
        in_b = 8'h3C;
        repeat (4) step();
        check("pre_rst_edge_a", rd_a, 32'hF);
        check("pre_rst_irq_a", {31'h0, irq_a}, 32'h1);
        apply_reset();
        bus(2'd1, 1'b0, 1'b1, 32'h0);
        step();
        check("post_rst_mask_a", rd_a, 32'h0);
        check("post_rst_mask_b", rd_b, 32'hA5);
        bus(2'd3, 1'b0, 1'b1, 32'h0);
        step();
        check("post_rst_edge_a", rd_a, 32'h0);
        check("post_rst_edge_b", rd_b, 32'h0);
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
